ps2_mouse_packet_rx: RTL
========================

// Module: ps2_mouse_packet_rx
// PURPOSE
//  Receives the raw PS/2 mouse line (PS2_CLK/PS2_DATA) and assembles 11-bit frames into 3-byte
//  movement packets: {Y, X, status}. Each valid packet is emitted with a one-cycle strobe.
//  It sits directly upstream of the mouse display top, which splits packet[7:0]/[15:8]/[23:16].
//  All logic runs in the system clock domain; the PS/2 lines are oversampled, not used as clocks.
// PARAMETERS
//  FILTER_LEN   8        consecutive equal samples needed before the filtered PS2_CLK changes
//  TIMEOUT_CYC  200000   idle cycles (2 ms @100 MHz) mid-frame/mid-packet before abandoning it
// PORTS
//  CLK100MHZ     in   1   system clock, all state on rising edge
//  CPU_RESETN    in   1   synchronous reset, active-low
//  PS2_CLK       in   1   raw PS/2 clock from mouse, asynchronous
//  PS2_DATA      in   1   raw PS/2 data from mouse, asynchronous
//  packet        out  24  [7:0] status, [15:8] X delta, [23:16] Y delta; holds the last good packet
//  packet_valid  out  1   one-cycle pulse, packet updated the same cycle
//  frame_err     out  1   one-cycle pulse: parity, start, stop or sync-bit violation
//  timeout_err   out  1   one-cycle pulse: partial frame/packet dropped on timeout
//  byte_idx      out  2   index of the next expected byte (0..2), debug
// BEHAVIOUR
//  Reset (CPU_RESETN=0 at a clock edge): packet=0, packet_valid=0, frame_err=0, timeout_err=0,
//   byte_idx=0, FSM=IDLE, filter output=1, timer=0. Mid-frame reset discards all partial data.
//  Input conditioning: two-flop synchroniser on both lines. The filtered clock changes only after
//   FILTER_LEN equal synchronised samples. A falling edge of the filtered clock gives a 1-cycle fall
//   strobe. The data bit is the synchronised PS2_DATA value in the fall-strobe cycle.
//  Frame FSM, advances only on fall:
//   IDLE  -> bit=0: START, bit count=0; bit=1: frame_err, stay IDLE
//   START -> DATA: shift LSB first, 8 bits, count 0..7
//   DATA  -> after bit 7: PARITY, check odd parity over the 8 data bits plus the parity bit
//   PARITY-> STOP: the stop bit must be 1
//   STOP  -> IDLE: byte accepted only if parity ok and stop=1; otherwise frame_err, byte_idx=0
//   The START state is transient and its only role is documentation. The implementation may merge
//   IDLE and START, provided the fall-to-bit mapping stays identical.
//  Packet assembly, on byte accept:
//   byte_idx=0: accepted only if status bit3 (always-1 sync bit) = 1; else frame_err, byte_idx=0
//   byte_idx=0/1: store the byte, byte_idx+1
//   byte_idx=2: next cycle packet<={byte2,byte1,byte0}, packet_valid=1, byte_idx=0
//  Latency: packet_valid is asserted exactly 1 cycle after the fall strobe of byte 2's stop bit.
//  Timeout: the timer clears on every fall and counts while FSM!=IDLE or byte_idx!=0. When it
//   reaches TIMEOUT_CYC-1: timeout_err pulse, FSM=IDLE, byte_idx=0. It saturates (no wrap) while idle.
//  Errors never modify packet. frame_err and timeout_err are mutually exclusive in one cycle;
//   a fall on the timeout cycle wins, clearing the timer, and no timeout is raised.
//  Movement bytes are passed through raw: no sign extension, no overflow clipping. Status bits
//   4/5 (sign) and 6/7 (overflow) are left to the consumer.
//  Host-to-device transmission is out of scope; both PS/2 lines are inputs only.
// STRUCTURE
//  Package ps2_pkg: frame state enum; byte offsets (STATUS=0, X=1, Y=2); status bit positions
//   (LEFT=0, RIGHT=1, MID=2, SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7).
//  Sub-module ps2_line_filter: synchroniser, FILTER_LEN debounce, fall strobe, synced data out.
//   Frame FSM, packet assembly and timeout timer stay in this module.
// TESTING
//  1 Bytes 08,05,FB sent as valid frames at a 70 us bit period -> one packet_valid, packet=24'hFB0508,
//    byte_idx returns to 0.
//  2 Byte 1 sent with wrong parity inside a 09,10,20 packet -> frame_err pulse, no packet_valid,
//    packet unchanged. A following good 09,10,20 -> packet=24'h201009.
//  3 First byte 00 (sync bit 0) -> frame_err, byte_idx stays 0. Then 18,FF,01 -> packet=24'h01FF18.
//  4 Send byte 0 and byte 1, then a silence longer than 2 ms -> exactly one timeout_err pulse,
//    byte_idx=0. A fresh 3-byte packet then decodes correctly.
//  5 Glitches on PS2_CLK shorter than FILTER_LEN cycles during a packet -> no extra bits shifted,
//    packet still correct.
//  6 CPU_RESETN low for 1 cycle after 6 data bits of byte 2 -> all outputs 0. The next full packet
//    decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse packet receiver.
// Frame states, packet byte offsets and status byte bit positions.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_DATA,
    FS_PARITY,
    FS_STOP
  } frame_state_e;

  localparam logic [1:0] BYTE_STATUS = 2'd0;
  localparam logic [1:0] BYTE_X      = 2'd1;
  localparam logic [1:0] BYTE_Y      = 2'd2;

  localparam int BIT_LEFT  = 0;
  localparam int BIT_RIGHT = 1;
  localparam int BIT_MID   = 2;
  localparam int BIT_SYNC  = 3;
  localparam int BIT_XSIGN = 4;
  localparam int BIT_YSIGN = 5;
  localparam int BIT_XOVF  = 6;
  localparam int BIT_YOVF  = 7;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: two-flop synchronisers, clock debounce,
// falling-edge strobe of the debounced clock and synced data bit.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    csync_q, csync_d;
  logic [1:0]    dsync_q, dsync_d;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Filtered clock moves only after FILTER_LEN consecutive differing samples
  always_comb begin
    csync_d = {csync_q[0], ps2_clk_i};
    dsync_d = {dsync_q[0], ps2_data_i};
    filt_d  = filt_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (csync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = csync_q[1];
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Register stage; lines idle high out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csync_q <= 2'b11;
      dsync_q <= 2'b11;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      csync_q <= csync_d;
      dsync_q <= dsync_d;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fall_o = fall_q;
  assign data_o = dsync_q[1];

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: 11-bit frame FSM, 3-byte packet assembly
// and a mid-frame/mid-packet inactivity timeout.
`timescale 1ns/1ps
module ps2_mouse_packet_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [23:0] packet,
  output logic        packet_valid,
  output logic        frame_err,
  output logic        timeout_err,
  output logic [1:0]  byte_idx
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC - 1);

  logic fall;
  logic bit_in;

  frame_state_e  state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_ok_q, par_ok_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic [23:0]   pkt_q, pkt_d;
  logic          pv_q, pv_d;
  logic          fe_q, fe_d;
  logic          te_q, te_d;
  logic [TW-1:0] tmr_q, tmr_d;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk       (CLK100MHZ),
    .rst_n     (CPU_RESETN),
    .ps2_clk_i (PS2_CLK),
    .ps2_data_i(PS2_DATA),
    .fall_o    (fall),
    .data_o    (bit_in)
  );

  // Frame decode on each fall; packet assembly on accepted bytes; timeout
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    par_ok_d = par_ok_q;
    idx_d    = idx_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    pkt_d    = pkt_q;
    pv_d     = 1'b0;
    fe_d     = 1'b0;
    te_d     = 1'b0;
    tmr_d    = tmr_q;
    if (fall) begin
      tmr_d = '0;
      unique case (state_q)
        FS_IDLE: begin
          if (!bit_in) begin
            state_d = FS_DATA;
            bcnt_d  = 3'd0;
          end else begin
            fe_d = 1'b1;
          end
        end
        FS_DATA: begin
          sh_d   = {bit_in, sh_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = FS_PARITY;
        end
        FS_PARITY: begin
          par_ok_d = ^{sh_q, bit_in};
          state_d  = FS_STOP;
        end
        FS_STOP: begin
          state_d = FS_IDLE;
          if (par_ok_q && bit_in) begin
            unique case (idx_q)
              BYTE_STATUS: begin
                if (sh_q[BIT_SYNC]) begin
                  b0_d  = sh_q;
                  idx_d = BYTE_X;
                end else begin
                  fe_d = 1'b1;
                end
              end
              BYTE_X: begin
                b1_d  = sh_q;
                idx_d = BYTE_Y;
              end
              BYTE_Y: begin
                pkt_d = {sh_q, b1_q, b0_q};
                pv_d  = 1'b1;
                idx_d = BYTE_STATUS;
              end
              default: idx_d = BYTE_STATUS;
            endcase
          end else begin
            fe_d  = 1'b1;
            idx_d = BYTE_STATUS;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end else if (state_q != FS_IDLE || idx_q != BYTE_STATUS) begin
      if (tmr_q == T_MAX) begin
        te_d    = 1'b1;
        state_d = FS_IDLE;
        idx_d   = BYTE_STATUS;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q  <= FS_IDLE;
      bcnt_q   <= '0;
      sh_q     <= '0;
      par_ok_q <= 1'b0;
      idx_q    <= BYTE_STATUS;
      b0_q     <= '0;
      b1_q     <= '0;
      pkt_q    <= '0;
      pv_q     <= 1'b0;
      fe_q     <= 1'b0;
      te_q     <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      par_ok_q <= par_ok_d;
      idx_q    <= idx_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      pkt_q    <= pkt_d;
      pv_q     <= pv_d;
      fe_q     <= fe_d;
      te_q     <= te_d;
      tmr_q    <= tmr_d;
    end
  end

  assign packet       = pkt_q;
  assign packet_valid = pv_q;
  assign frame_err    = fe_q;
  assign timeout_err  = te_q;
  assign byte_idx     = idx_q;

endmodule
